// File: rtl/washer_panel_pkg.sv
// Shared definitions for the washer front-panel input path.
// Holds the key indices, the per-key FSM state type and a counter-width helper.
package washer_panel_pkg;

  localparam int KEY_RESET = 0;
  localparam int KEY_RUN   = 1;
  localparam int KEY_WATER = 2;
  localparam int KEY_OPEN  = 3;
  localparam int KEY_CLICK = 4;
  localparam int NUM_KEYS  = 5;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG
  } keyState_e;

  // One spare bit over $clog2 so a counter can hold the parameter value itself.
  function automatic int cntWidth(input int maxVal);
    return $clog2(maxVal) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One panel key: 2-flop synchronizer, debounce counter, IDLE/HELD/LONG FSM.
// Auto-repeat counter exists only when PANEL_AUTO_REPEAT_EN is defined.
module key_debounce_fsm
  import washer_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int LONG_CYCLES     = 1000000,
  parameter int REPEAT_CYCLES   = 250000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rawKey,
  output logic keyLevel,
  output logic keyPress,
  output logic keyLong,
  output logic keyRelease
);

  localparam int DbW   = cntWidth(DEBOUNCE_CYCLES);
  localparam int HoldW = cntWidth(LONG_CYCLES);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic [1:0]       syncFf;
  logic [DbW-1:0]   dbCnt;
  logic [HoldW-1:0] holdCnt;
  keyState_e        state, nextState;
  logic             synced, mismatch, accept, longHit, repeatHit;
  logic             pressNext, longNext, releaseNext;

  assign synced   = syncFf[1];
  assign keyLevel = (state != IDLE);
  assign mismatch = (synced != keyLevel);
  assign accept   = mismatch && (dbCnt == DbLast);
  assign longHit  = (state == HELD) && (holdCnt == HoldLast);

`ifdef PANEL_AUTO_REPEAT_EN
  localparam int RepW = cntWidth(REPEAT_CYCLES);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
  logic [RepW-1:0] repCnt;

  // Free-running period counter while in LONG; restarts on every repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repCnt <= '0;
    end else if (state == LONG && repCnt != RepLast) begin
      repCnt <= repCnt + RepW'(1);
    end else begin
      repCnt <= '0;
    end
  end

  assign repeatHit = REPEAT_EN && (state == LONG) && (repCnt == RepLast);
`else
  assign repeatHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncFf     <= '0;
      dbCnt      <= '0;
      holdCnt    <= '0;
      state      <= IDLE;
      keyPress   <= 1'b0;
      keyLong    <= 1'b0;
      keyRelease <= 1'b0;
    end else begin
      syncFf     <= {syncFf[0], rawKey};
      state      <= nextState;
      keyPress   <= pressNext;
      keyLong    <= longNext;
      keyRelease <= releaseNext;
      if (!mismatch || accept) begin
        dbCnt <= '0;
      end else if (dbCnt != DbLast) begin
        dbCnt <= dbCnt + DbW'(1);
      end
      if (state == HELD && holdCnt != HoldLast) begin
        holdCnt <= holdCnt + HoldW'(1);
      end else begin
        holdCnt <= '0;
      end
    end
  end

  // An accepted fall outranks the long and repeat thresholds in the same cycle.
  always_comb begin
    nextState   = state;
    pressNext   = 1'b0;
    longNext    = 1'b0;
    releaseNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nextState = HELD;
          pressNext = 1'b1;
        end
      end
      HELD: begin
        if (accept) begin
          nextState   = IDLE;
          releaseNext = 1'b1;
        end else if (longHit) begin
          nextState = LONG;
          longNext  = 1'b1;
        end
      end
      LONG: begin
        if (accept) begin
          nextState   = IDLE;
          releaseNext = 1'b1;
        end else if (repeatHit) begin
          pressNext = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: rtl/panel_key_decoder.sv
// Washer front-panel decoder: five debounced keys plus the key-click beeper.
// Define PANEL_AUTO_REPEAT_EN to enable auto-repeat for keys in REPEAT_MASK.
module panel_key_decoder
  import washer_panel_pkg::*;
#(
  parameter int             DEBOUNCE_CYCLES = 20000,
  parameter int             LONG_CYCLES     = 1000000,
  parameter int             REPEAT_CYCLES   = 250000,
  parameter logic [4:0]     REPEAT_MASK     = 5'b10000,
  parameter int             BEEP_CYCLES     = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in_keys,
  output logic [4:0] key_level,
  output logic [4:0] key_press,
  output logic [4:0] key_long,
  output logic [4:0] key_release,
  output logic       beep_out
);

  localparam int BeepW = cntWidth(BEEP_CYCLES);

  logic [BeepW-1:0] beepCnt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_MASK[k])
    ) uKey (
      .clk       (clk),
      .rst_n     (rst_n),
      .rawKey    (in_keys[k]),
      .keyLevel  (key_level[k]),
      .keyPress  (key_press[k]),
      .keyLong   (key_long[k]),
      .keyRelease(key_release[k])
    );
  end

  // Any press (repeats included) reloads the click; simultaneous presses load once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beepCnt <= '0;
    end else if (|key_press) begin
      beepCnt <= BeepW'(BEEP_CYCLES);
    end else if (beepCnt != '0) begin
      beepCnt <= beepCnt - BeepW'(1);
    end
  end

  assign beep_out = (beepCnt != '0);

endmodule

// File: tb/tb_panel_key_decoder.sv
// Directed self-checking bench for panel_key_decoder with short timing parameters.
// Auto-repeat expectations follow whether PANEL_AUTO_REPEAT_EN is defined.
module tb_panel_key_decoder;

  localparam int DB   = 4;
  localparam int LNG  = 10;
  localparam int REP  = 3;
  localparam int BEEP = 5;

`ifdef PANEL_AUTO_REPEAT_EN
  localparam int ClickPresses = 5;
  localparam int ClickBeeps   = 19;
`else
  localparam int ClickPresses = 1;
  localparam int ClickBeeps   = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] in_keys;
  logic [4:0] key_level, key_press, key_long, key_release;
  logic       beep_out;

  int cyc = 0;
  int compareCount = 0;
  int mismatchCount = 0;
  int pressCnt[5], longCnt[5], relCnt[5];
  int firstPress[5], firstLong[5], firstRel[5];
  int beepCycles, beepFirst;
  logic [4:0] pressVec;
  int startEdge, relEdge;

  panel_key_decoder #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LNG),
    .REPEAT_CYCLES  (REP),
    .REPEAT_MASK    (5'b10000),
    .BEEP_CYCLES    (BEEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_keys    (in_keys),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_long   (key_long),
    .key_release(key_release),
    .beep_out   (beep_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: counts pulses per key and remembers when each first appeared.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 5; k++) begin
        if (key_press[k]) begin
          pressCnt[k]++;
          if (firstPress[k] < 0) firstPress[k] = cyc;
        end
        if (key_long[k]) begin
          longCnt[k]++;
          if (firstLong[k] < 0) firstLong[k] = cyc;
        end
        if (key_release[k]) begin
          relCnt[k]++;
          if (firstRel[k] < 0) firstRel[k] = cyc;
        end
      end
      if (beep_out) begin
        beepCycles++;
        if (beepFirst < 0) beepFirst = cyc;
      end
      if (key_press != 5'b0 && pressVec == 5'b0) pressVec = key_press;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearStats();
    for (int k = 0; k < 5; k++) begin
      pressCnt[k]   = 0;
      longCnt[k]    = 0;
      relCnt[k]     = 0;
      firstPress[k] = -1;
      firstLong[k]  = -1;
      firstRel[k]   = -1;
    end
    beepCycles = 0;
    beepFirst  = -1;
    pressVec   = 5'b0;
  endtask

  // Drives the raw keys; startEdge is the clock edge that first samples them.
  task automatic applyStimulus(input logic [4:0] keys);
    in_keys   = keys;
    startEdge = cyc + 1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    in_keys = 5'b0;
    clearStats();
    #2;
    rst_n   = 1'b0;
    in_keys = 5'b11111;
    tick(3);
    checkOutput("rst_level", int'(key_level), 0);
    checkOutput("rst_pulses", int'({key_press, key_long, key_release}), 0);
    checkOutput("rst_beep", int'(beep_out), 0);

    // Keys held through reset release become fresh presses.
    rst_n = 1'b1;
    startEdge = cyc + 1;
    tick(8);
    applyStimulus(5'b00000);
    tick(12);
    checkOutput("rst_pressVec", int'(pressVec), 31);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rst_pressCnt%0d", k), pressCnt[k], 1);
      checkOutput($sformatf("rst_pressLat%0d", k), firstPress[k] - (startEdge - 8), DB + 1);
    end
    checkOutput("rst_beepLen", beepCycles, BEEP);
    checkOutput("rst_beepStart", beepFirst - firstPress[0], 1);
    checkOutput("rst_relLat", firstRel[4] - startEdge, DB + 1);
    checkOutput("rst_noLong", longCnt[0] + longCnt[1] + longCnt[2] + longCnt[3] + longCnt[4], 0);

    // Bouncing run key: 2-cycle glitches never reach the debounce threshold.
    clearStats();
    for (int i = 0; i < 10; i++) begin
      in_keys[1] = ~in_keys[1];
      tick(2);
    end
    checkOutput("bnc_noPressYet", pressCnt[1], 0);
    applyStimulus(5'b00010);
    tick(8);
    relEdge = cyc + 1;
    applyStimulus(5'b00000);
    tick(12);
    checkOutput("bnc_pressCnt", pressCnt[1], 1);
    checkOutput("bnc_pressLat", firstPress[1] - (relEdge - 8), DB + 1);
    checkOutput("bnc_noLong", longCnt[1], 0);
    checkOutput("bnc_relCnt", relCnt[1], 1);

    // Long press on water: not repeat-eligible.
    clearStats();
    applyStimulus(5'b00100);
    relEdge = startEdge + 30;
    tick(30);
    applyStimulus(5'b00000);
    tick(12);
    checkOutput("lng_pressCnt", pressCnt[2], 1);
    checkOutput("lng_pressLat", firstPress[2] - (relEdge - 30), DB + 1);
    checkOutput("lng_longCnt", longCnt[2], 1);
    checkOutput("lng_longDelay", firstLong[2] - firstPress[2], LNG);
    checkOutput("lng_relLat", firstRel[2] - relEdge, DB + 1);

    // Click key held 25 cycles: repeats at +18,+21,+24,+27; the +30 repeat loses to release.
    clearStats();
    applyStimulus(5'b10000);
    relEdge = startEdge + 25;
    tick(25);
    applyStimulus(5'b00000);
    tick(15);
    checkOutput("rpt_pressCnt", pressCnt[4], ClickPresses);
    checkOutput("rpt_longCnt", longCnt[4], 1);
    checkOutput("rpt_longDelay", firstLong[4] - firstPress[4], LNG);
    checkOutput("rpt_relLat", firstRel[4] - relEdge, DB + 1);
    checkOutput("rpt_beepCycles", beepCycles, ClickBeeps);

    // Run and open together: one press vector, one beep.
    clearStats();
    applyStimulus(5'b01010);
    tick(8);
    applyStimulus(5'b00000);
    tick(12);
    checkOutput("sim_pressVec", int'(pressVec), 10);
    checkOutput("sim_beepLen", beepCycles, BEEP);
    checkOutput("sim_relOpen", relCnt[3], 1);

    // Reset asserted while a key is held and the beeper is running.
    clearStats();
    applyStimulus(5'b00001);
    tick(8);
    checkOutput("mid_levelBefore", int'(key_level), 1);
    checkOutput("mid_beepBefore", int'(beep_out), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_levelAfter", int'(key_level), 0);
    checkOutput("mid_beepAfter", int'(beep_out), 0);
    in_keys = 5'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    checkOutput("mid_levelIdle", int'(key_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
